// File: rtl/posedge_jk_ff_w_clr.sv
// Single-bit JK flip-flop, rising-edge clocked, with asynchronous active-low clear.
// Q comes straight from the state bit and Q_n is always its complement.
module posedge_jk_ff_w_clr (
  input  logic CLK,
  input  logic CLR,
  input  logic J,
  input  logic K,
  output logic Q,
  output logic Q_n
);

  logic state_q;
  logic state_d;

  // Next-state decode following the JK truth table
  always_comb begin
    state_d = state_q;
    case ({J, K})
      2'b00:   state_d = state_q;
      2'b01:   state_d = 1'b0;
      2'b10:   state_d = 1'b1;
      2'b11:   state_d = ~state_q;
      default: state_d = state_q;
    endcase
  end

  // State register; clear wins over any clock edge while CLR is low
  always_ff @(posedge CLK or negedge CLR) begin
    if (!CLR) begin
      state_q <= 1'b0;
    end else begin
      state_q <= state_d;
    end
  end

  assign Q   = state_q;
  assign Q_n = ~state_q;

  posedge_jk_ff_w_clr_chk u_chk (
    .CLK (CLK),
    .CLR (CLR),
    .Q   (Q),
    .Q_n (Q_n)
  );

endmodule

// Structural invariants of the flip-flop outputs.
module posedge_jk_ff_w_clr_chk (
  input logic CLK,
  input logic CLR,
  input logic Q,
  input logic Q_n
);

  // Outputs must be complementary and cleared whenever CLR is low
  always @(negedge CLK) begin
    if (!CLR) begin
      assert (Q == 1'b0 && Q_n == 1'b1) else $error("FAIL chk_clear: Q=%b Q_n=%b", Q, Q_n);
    end else begin
      assert (Q != Q_n) else $error("FAIL chk_complement: Q=%b Q_n=%b", Q, Q_n);
    end
  end

endmodule

// File: tb/tb_posedge_jk_ff_w_clr.sv
// Directed bench for posedge_jk_ff_w_clr: clear, truth table, toggle runs,
// async clear mid-cycle, release behaviour and edge isolation.
module tb_posedge_jk_ff_w_clr;

  logic CLK;
  logic CLR;
  logic J;
  logic K;
  logic Q;
  logic Q_n;

  int checks = 0;
  int errors = 0;

  posedge_jk_ff_w_clr dut (
    .CLK (CLK),
    .CLR (CLR),
    .J   (J),
    .K   (K),
    .Q   (Q),
    .Q_n (Q_n)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  task automatic chk(input string tag, input logic exp_q);
    checks++;
    assert (Q === exp_q) else begin
      errors++;
      $error("FAIL %s: Q=%b expected %b", tag, Q, exp_q);
    end
    checks++;
    assert (Q_n === ~exp_q) else begin
      errors++;
      $error("FAIL %s_n: Q_n=%b expected %b", tag, Q_n, ~exp_q);
    end
  endtask

  // Drive J/K on the falling edge, then sample just after the next rising edge
  task automatic edge_with(input logic j, input logic k);
    @(negedge CLK);
    J = j;
    K = k;
    @(posedge CLK);
    #1;
  endtask

  initial begin
    CLR = 1'b0;
    J   = 1'b1;
    K   = 1'b0;
    #1;
    chk("reset", 1'b0);

    // Clock keeps running under clear with a set request
    for (int i = 0; i < 4; i++) begin
      @(posedge CLK);
      #1;
      chk("clr_hold_pos", 1'b0);
      @(negedge CLK);
      #1;
      chk("clr_hold_neg", 1'b0);
    end

    // Release between edges, then first rising edge sets
    CLR = 1'b1;
    #1;
    chk("release_idle", 1'b0);
    @(posedge CLK);
    #1;
    chk("first_set", 1'b1);

    // Truth table starting from Q=1
    edge_with(1'b0, 1'b0); chk("tt_hold", 1'b1);
    edge_with(1'b0, 1'b1); chk("tt_reset", 1'b0);
    edge_with(1'b1, 1'b1); chk("tt_toggle", 1'b1);
    edge_with(1'b0, 1'b0); chk("tt_hold2", 1'b1);
    edge_with(1'b1, 1'b0); chk("tt_set", 1'b1);

    // Toggle run from Q=0
    edge_with(1'b0, 1'b1); chk("tog_start", 1'b0);
    edge_with(1'b1, 1'b1); chk("tog1", 1'b1);
    edge_with(1'b1, 1'b1); chk("tog2", 1'b0);
    edge_with(1'b1, 1'b1); chk("tog3", 1'b1);
    edge_with(1'b1, 1'b1); chk("tog4", 1'b0);

    // Async clear while Q=1, away from any rising edge
    edge_with(1'b1, 1'b0); chk("pre_clr_set", 1'b1);
    #2;
    CLR = 1'b0;
    #1;
    chk("async_clr", 1'b0);
    edge_with(1'b0, 1'b1); chk("clr_ign_reset", 1'b0);
    edge_with(1'b1, 1'b1); chk("clr_ign_toggle", 1'b0);

    // Release with J=K=1 between edges, then toggle up, then reset
    @(negedge CLK);
    J   = 1'b1;
    K   = 1'b1;
    CLR = 1'b1;
    #1;
    chk("rel_wait", 1'b0);
    @(posedge CLK);
    #1;
    chk("rel_toggle", 1'b1);
    edge_with(1'b0, 1'b1); chk("rel_reset", 1'b0);

    // Edge isolation: J/K changed only while CLK is high or on falling edges
    #1;
    J = 1'b1;
    K = 1'b0;
    #1;
    chk("iso_high_set", 1'b0);
    @(negedge CLK);
    #1;
    chk("iso_neg", 1'b0);
    J = 1'b1;
    K = 1'b1;
    @(posedge CLK);
    #1;
    chk("iso_toggle", 1'b1);
    J = 1'b0;
    K = 1'b1;
    #2;
    chk("iso_high_reset", 1'b1);
    @(negedge CLK);
    #1;
    chk("iso_neg2", 1'b1);
    J = 1'b0;
    K = 1'b0;
    @(posedge CLK);
    #1;
    chk("iso_hold", 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
